// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: transmit FSM states, SDA line levels, default word width.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    ACK_WAIT   = 2'd2,
    ACK_SAMPLE = 2'd3
  } tx_state_t;

  // SDA level seen during the acknowledge bit
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int I2C_DATA_WIDTH = 8;

endpackage

// File: rtl/i2c_bus_edge_detect.sv
// SCL edge and START/STOP detector on pre-synchronised bus lines.
// Zero-latency combinational flags against registered last states; no backpressure.
module i2c_bus_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_last;
  logic sda_last;

  // Idle bus is high on both lines, so the first sample after reset is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_last <= 1'b1;
      sda_last <= 1'b1;
    end else begin
      scl_last <= scl;
      sda_last <= sda_in;
    end
  end

  assign scl_rise  = ~scl_last & scl;
  assign scl_fall  = scl_last & ~scl;
  assign start_det = scl & scl_last & sda_last & ~sda_in;
  assign stop_det  = scl & scl_last & ~sda_last & sda_in;

endmodule

// File: rtl/i2c_slave_write_byte.sv
// Slave-side byte transmitter for master reads: shifts a word MSB-first onto SDA, then samples ACK.
// Bit appears one clock after enable / detected SCL fall; START or STOP mid-byte aborts.
module i2c_slave_write_byte
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  busy,
  output logic                  finish,
  output logic                  ack,
  output logic                  abort
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [CW-1:0]         bit_cnt;
  // Holds only the bits not yet on the pad; the MSB goes straight to sda_out at load.
  logic [DATA_WIDTH-2:0] shreg;

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_cond;

  i2c_bus_edge_detect u_edge (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign bus_cond = start_det | stop_det;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      sda_out <= 1'b1;
      busy    <= 1'b0;
      finish  <= 1'b0;
      ack     <= 1'b0;
      abort   <= 1'b0;
    end else begin
      finish <= 1'b0;
      abort  <= 1'b0;
      if (state != IDLE && bus_cond) begin
        // A bus condition mid-transfer means the master has moved on; let go of the line.
        state   <= IDLE;
        sda_out <= 1'b1;
        busy    <= 1'b0;
        abort   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            sda_out <= 1'b1;
            if (enable && !scl) begin
              shreg   <= data_in[DATA_WIDTH-2:0];
              sda_out <= data_in[DATA_WIDTH-1];
              bit_cnt <= '0;
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (scl_rise) begin
              if (bit_cnt == LAST_BIT) begin
                state <= ACK_WAIT;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (scl_fall) begin
              sda_out <= shreg[DATA_WIDTH-2];
              shreg   <= shreg << 1;
            end
          end
          ACK_WAIT: begin
            if (scl_fall) begin
              sda_out <= 1'b1;
              state   <= ACK_SAMPLE;
            end
          end
          ACK_SAMPLE: begin
            if (scl_rise) begin
              ack    <= (sda_in == I2C_ACK);
              finish <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
          default: begin
            state   <= IDLE;
            sda_out <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_write_byte.sv
// Directed bench for i2c_slave_write_byte: master-side SCL/SDA model with hand-computed expectations.
module tb_i2c_slave_write_byte;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_out;
  logic       busy;
  logic       finish;
  logic       ack;
  logic       abort;

  int n_checks = 0;
  int n_pass   = 0;

  // Byte-level results collected by run_byte
  logic [7:0] r_byte;
  logic       r_rel;
  int         r_fin;
  int         r_abt;
  int         r_glitch;
  logic       r_busy_fin;
  logic       r_ack_fin;
  int         inject_bit = -1;

  assign sda_in = sda_out & m_sda;

  always #5 clock = ~clock;

  i2c_slave_write_byte #(.DATA_WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .data_in (data_in),
    .scl     (scl),
    .sda_in  (sda_in),
    .sda_out (sda_out),
    .busy    (busy),
    .finish  (finish),
    .ack     (ack),
    .abort   (abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // One SCL bit period starting with SCL low; returns the SDA bit seen before the rising edge.
  task automatic clock_bit(input logic mdrive, output logic bit_seen);
    tick();
    m_sda = mdrive;
    tick();
    tick();
    bit_seen = sda_out;
    scl = 1'b1;
    repeat (4) begin
      tick();
      if (finish) begin
        r_fin++;
        r_busy_fin = busy;
        r_ack_fin  = ack;
      end
      if (abort) r_abt++;
      if (sda_out !== bit_seen && !finish) r_glitch++;
    end
    scl = 1'b0;
  endtask

  task automatic pulse_enable(input logic [7:0] d);
    data_in = d;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
  endtask

  task automatic run_byte(input logic [7:0] d, input logic master_ack);
    logic b;
    r_byte = 8'h00; r_fin = 0; r_abt = 0; r_glitch = 0;
    r_busy_fin = 1'bx; r_ack_fin = 1'bx;
    pulse_enable(d);
    for (int i = 0; i < 8; i++) begin
      if (i == inject_bit) pulse_enable(8'h00);
      clock_bit(1'b1, b);
      r_byte = {r_byte[6:0], b};
    end
    clock_bit(master_ack ? 1'b0 : 1'b1, b);
    r_rel = b;
    tick();
    m_sda = 1'b1;
  endtask

  initial begin
    logic b;
    int fin_total;

    // Reset state
    repeat (3) tick();
    check("rst_sda_out", sda_out, 1);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_ack", ack, 0);
    check("rst_abort", abort, 0);
    reset = 1'b0;
    tick();
    scl = 1'b0;
    tick();
    tick();

    // Basic byte with ACK
    run_byte(8'hA5, 1'b1);
    check("a5_byte", r_byte, 8'hA5);
    check("a5_released", r_rel, 1);
    check("a5_finish_cnt", r_fin, 1);
    check("a5_ack_at_fin", r_ack_fin, 1);
    check("a5_busy_at_fin", r_busy_fin, 0);
    check("a5_sda_stable_high", r_glitch, 0);
    check("a5_abort_cnt", r_abt, 0);
    check("a5_ack_hold", ack, 1);

    // NACK
    run_byte(8'h3C, 1'b0);
    check("3c_byte", r_byte, 8'h3C);
    check("3c_finish_cnt", r_fin, 1);
    check("3c_ack_at_fin", r_ack_fin, 0);

    // Enable with SCL high is ignored
    scl = 1'b1;
    tick();
    tick();
    pulse_enable(8'h00);
    tick();
    check("scl_hi_en_busy", busy, 0);
    check("scl_hi_en_sda", sda_out, 1);
    scl = 1'b0;
    tick();
    tick();

    // Enable during SHIFT is ignored
    inject_bit = 3;
    run_byte(8'h96, 1'b1);
    inject_bit = -1;
    check("inject_byte", r_byte, 8'h96);
    check("inject_finish_cnt", r_fin, 1);

    // START mid-byte aborts
    r_fin = 0; r_abt = 0;
    pulse_enable(8'hFF);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, b);
    tick(); tick(); tick();
    scl = 1'b1;
    tick();
    tick();
    m_sda = 1'b0;
    tick();
    check("abort_pulse", abort, 1);
    check("abort_busy", busy, 0);
    check("abort_sda", sda_out, 1);
    check("abort_no_finish", finish, 0);
    tick();
    check("abort_one_clock", abort, 0);
    m_sda = 1'b1;
    tick();
    check("idle_stop_ignored", abort, 0);
    check("abort_fin_cnt", r_fin, 0);
    scl = 1'b0;
    tick();
    tick();

    // Reset mid-byte, then a clean transfer
    pulse_enable(8'h0F);
    for (int i = 0; i < 5; i++) clock_bit(1'b1, b);
    tick();
    check("rstmid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("rstmid_sda", sda_out, 1);
    check("rstmid_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    run_byte(8'h81, 1'b1);
    check("post_rst_byte", r_byte, 8'h81);
    check("post_rst_finish_cnt", r_fin, 1);
    check("post_rst_ack", r_ack_fin, 1);

    // Back-to-back bytes
    run_byte(8'h12, 1'b1);
    check("b2b_first", r_byte, 8'h12);
    fin_total = r_fin;
    run_byte(8'h34, 1'b1);
    check("b2b_second", r_byte, 8'h34);
    fin_total += r_fin;
    check("b2b_finish_cnt", fin_total, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
